// File: rtl/mul_pack_pkg.sv
// mul_pack_pkg: shared field widths, limits and the stage payload type for
// the multiplier result packer (mul_pack) and its rounding helper.
package mul_pack_pkg;

  // Packed FP16-variant field widths: {sign, exp[3:0], frac[10:0]}
  localparam int SGN_W  = 1;
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 11;

  // Default exponent bias of the packed FP format
  localparam int DEFAULT_BIAS = 7;

  // Internal widths: pre-round exponent carries one extra bit so that
  // overflow from normalization and rounding is visible downstream
  localparam int E_W    = EXP_W + 1;
  localparam int MAG_W  = 14;
  localparam int DATA_W = MAG_W + 1;

  // Saturation values
  localparam logic [14:0] FP_MAX_MAG  = 15'h7FFF;
  localparam logic [6:0]  INT_MAX_MAG = 7'h7F;

  // Operating mode carried alongside each data item
  typedef enum logic {
    MODE_INT = 1'b0,
    MODE_FP  = 1'b1
  } mode_e;

  // Payload passed between pipeline stages. data holds the FP fraction in
  // its low FRAC_W bits, or the INT magnitude (plus round carry after
  // stage 2).
  typedef struct packed {
    mode_e             fp;
    logic              sgn;
    logic              zero;
    logic [E_W-1:0]    e;
    logic [DATA_W-1:0] data;
    logic              guard;
    logic              sticky;
  } stage_t;

  // Assemble the INT-mode output word from sign and 7-bit magnitude
  function automatic logic [15:0] pack_int(input logic s, input logic [6:0] mag);
    return {8'h00, s, mag};
  endfunction

  // Assemble the FP-mode output word from sign, exponent and fraction
  function automatic logic [15:0] pack_fp(input logic s, input logic [EXP_W-1:0] e,
                                          input logic [FRAC_W-1:0] frac);
    return {s, e, frac};
  endfunction

endpackage

// File: rtl/mul_pack_round.sv
// mul_pack_round: combinational round-half-to-even increment. Adds one to
// val when the discarded part is above half, or exactly half with an odd
// val. carry reports the overflow out of the W-bit field.
module mul_pack_round #(
  parameter int W = 11
) (
  input  logic [W-1:0] val,
  input  logic         guard,
  input  logic         sticky,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic         inc;
  logic [W:0]   total;

  // Decide the RNE increment and add it with one bit of headroom
  always_comb begin
    inc   = guard & (sticky | val[0]);
    total = {1'b0, val} + {{W{1'b0}}, inc};
  end

  assign sum   = total[W-1:0];
  assign carry = total[W];

endmodule

// File: rtl/mul_pack.sv
// mul_pack: packs the unpacked product triple (mantissa, biased exponent,
// sign) into the packed operand word. Three-stage valid/ready pipeline:
// normalize, round (RNE), saturate/pack. A single global stall freezes all
// stages while the output is held.
// Optional build macro MUL_PACK_STATUS_EN adds sticky status outputs
// (stat_ovf, stat_inexact, stat_cnt) with a synchronous clear (stat_clr).
module mul_pack
  import mul_pack_pkg::*;
#(
  parameter int EXP_BIAS  = DEFAULT_BIAS,
  parameter int INT_SHIFT = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        fp_sel,
  input  logic [15:0] man,
  input  logic [3:0]  exp,
  input  logic        sgn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        ovf
`ifdef MUL_PACK_STATUS_EN
  ,
  input  logic        stat_clr,
  output logic        stat_ovf,
  output logic        stat_inexact,
  output logic [7:0]  stat_cnt
`endif
);

  // Parameter sanity: the datapath is bias-agnostic, but a bias outside
  // the exponent field makes no sense, and the INT shift must fit 0..7
  if (INT_SHIFT < 0 || INT_SHIFT > 7) begin : g_bad_shift
    $error("mul_pack: INT_SHIFT must be in 0..7");
  end
  if (EXP_BIAS < 0 || EXP_BIAS > 15) begin : g_bad_bias
    $error("mul_pack: EXP_BIAS must be in 0..15");
  end

  // Bits of man[15:2] below the guard position (guard sits at INT_SHIFT-1)
  localparam logic [14:0] STICKY_MASK = 15'((32'd1 << INT_SHIFT) - 32'd1);

  logic        stall;
  logic        advance;
  logic        v1;
  logic        v2;
  stage_t      p1;
  stage_t      p2;
  stage_t      norm;
  stage_t      rounded;

  logic [14:0] int_ext;
  logic [14:0] int_shifted;

  logic [FRAC_W-1:0] fp_sum;
  logic              fp_carry;
  logic [MAG_W-1:0]  int_sum;
  logic              int_carry;

  logic [15:0] pack_result;
  logic        pack_ovf;
  logic        pack_inexact;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

  // The appended zero makes the guard bit land at shifted[0] for every
  // shift, including 0 where it reads the constant zero
  assign int_ext     = {man[15:2], 1'b0};
  assign int_shifted = int_ext >> INT_SHIFT;

  // Stage 1 (comb): normalize the incoming triple into fraction/magnitude
  // plus guard and sticky bits
  always_comb begin
    norm     = '0;
    norm.fp  = mode_e'(fp_sel);
    norm.sgn = sgn;
    if (fp_sel) begin
      norm.zero = (man == 16'h0000);
      if (man[15]) begin
        norm.e      = {1'b0, exp} + 5'd1;
        norm.data   = {4'b0000, man[14:4]};
        norm.guard  = man[3];
        norm.sticky = |man[2:0];
      end else begin
        norm.e      = {1'b0, exp};
        norm.data   = {4'b0000, man[13:3]};
        norm.guard  = man[2];
        norm.sticky = |man[1:0];
      end
    end else begin
      norm.data   = {1'b0, int_shifted[14:1]};
      norm.guard  = int_shifted[0];
      norm.sticky = |(int_ext & STICKY_MASK);
    end
  end

  mul_pack_round #(.W(FRAC_W)) u_round_fp (
    .val    (p1.data[FRAC_W-1:0]),
    .guard  (p1.guard),
    .sticky (p1.sticky),
    .sum    (fp_sum),
    .carry  (fp_carry)
  );

  mul_pack_round #(.W(MAG_W)) u_round_int (
    .val    (p1.data[MAG_W-1:0]),
    .guard  (p1.guard),
    .sticky (p1.sticky),
    .sum    (int_sum),
    .carry  (int_carry)
  );

  // Stage 2 (comb): apply the rounding increment; an FP fraction carry
  // wraps the fraction to zero and bumps the exponent
  always_comb begin
    rounded = p1;
    if (p1.fp == MODE_FP) begin
      rounded.data = {4'b0000, fp_sum};
      rounded.e    = p1.e + {4'b0000, fp_carry};
    end else begin
      rounded.data = {int_carry, int_sum};
    end
  end

  // Stage 3 (comb): saturate out-of-range values and assemble the word
  always_comb begin
    pack_result  = 16'h0000;
    pack_ovf     = 1'b0;
    pack_inexact = p2.guard | p2.sticky;
    if (p2.fp == MODE_FP) begin
      if (p2.e[E_W-1]) begin
        pack_result = {p2.sgn, FP_MAX_MAG};
        pack_ovf    = 1'b1;
      end else if (p2.zero) begin
        pack_result = {p2.sgn, 15'h0000};
      end else begin
        pack_result = pack_fp(p2.sgn, p2.e[EXP_W-1:0], p2.data[FRAC_W-1:0]);
      end
    end else begin
      if (p2.data > 15'd127) begin
        pack_result = pack_int(p2.sgn, INT_MAX_MAG);
        pack_ovf    = 1'b1;
      end else begin
        pack_result = pack_int(p2.sgn, p2.data[6:0]);
      end
    end
  end

  // Pipeline registers: all stages move together unless the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      p1        <= '0;
      p2        <= '0;
      result    <= 16'h0000;
      ovf       <= 1'b0;
    end else if (advance) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) begin
        p1 <= norm;
      end
      if (v1) begin
        p2 <= rounded;
      end
      if (v2) begin
        result <= pack_result;
        ovf    <= pack_ovf;
      end
    end
  end

`ifdef MUL_PACK_STATUS_EN
  logic out_inexact;
  logic out_xfer;

  assign out_xfer = out_valid & out_ready;

  // Inexact flag travels with the result into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inexact <= 1'b0;
    end else if (advance && v2) begin
      out_inexact <= pack_inexact;
    end
  end

  // Sticky status: updated only on output transfer, clear beats set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ovf     <= 1'b0;
      stat_inexact <= 1'b0;
      stat_cnt     <= 8'd0;
    end else if (stat_clr) begin
      stat_ovf     <= 1'b0;
      stat_inexact <= 1'b0;
      stat_cnt     <= 8'd0;
    end else if (out_xfer) begin
      if (ovf) begin
        stat_ovf <= 1'b1;
        if (stat_cnt != 8'hFF) begin
          stat_cnt <= stat_cnt + 8'd1;
        end
      end
      if (out_inexact) begin
        stat_inexact <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul_pack.sv
// tb_mul_pack: scoreboard bench for mul_pack. Two instances share inputs:
// dut uses INT_SHIFT = 7, dut_s0 uses INT_SHIFT = 0. Expected words come
// from an arithmetic reference model and are queued at input transfer,
// then compared at output transfer.
module tb_mul_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        fp_sel;
  logic [15:0] man;
  logic [3:0]  exp;
  logic        sgn;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] result;
  logic        ovf;

  logic        in_ready_s0;
  logic        out_valid_s0;
  logic [15:0] result_s0;
  logic        ovf_s0;

  int assert_count = 0;
  int fail_count   = 0;

  logic [16:0] q7[$];
  logic [16:0] q0[$];

  mul_pack #(.INT_SHIFT(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_sel    (fp_sel),
    .man       (man),
    .exp       (exp),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf)
  );

  mul_pack #(.INT_SHIFT(0)) dut_s0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s0),
    .fp_sel    (fp_sel),
    .man       (man),
    .exp       (exp),
    .sgn       (sgn),
    .out_valid (out_valid_s0),
    .out_ready (out_ready),
    .result    (result_s0),
    .ovf       (ovf_s0)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  // Round-to-nearest-even of v >> sh using plain integer arithmetic
  function automatic int rne_shift(input int v, input int sh);
    int q, rem, half;
    if (sh == 0) return v;
    q    = v >> sh;
    rem  = v & ((1 << sh) - 1);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    return q;
  endfunction

  // Reference model: returns {ovf, result}
  function automatic logic [16:0] model(input logic f, input logic [15:0] m,
                                        input logic [3:0] ex, input logic s,
                                        input int shift);
    int q, e, sh;
    logic [15:0] w;
    if (f) begin
      if (m == 16'h0000) return {1'b0, s, 15'h0000};
      sh = m[15] ? 4 : 3;
      e  = int'(ex) + (m[15] ? 1 : 0);
      q  = rne_shift(int'(m), sh);
      if (q >= 4096) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e > 15) return {1'b1, s, 15'h7FFF};
      w = {s, e[3:0], q[10:0]};
      return {1'b0, w};
    end else begin
      q = rne_shift(int'(m[15:2]), shift);
      if (q > 127) return {1'b1, 8'h00, s, 7'h7F};
      w = {8'h00, s, q[6:0]};
      return {1'b0, w};
    end
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [16:0] e7;
    logic [16:0] e0;
    if (!rst_n) begin
      q7.delete();
      q0.delete();
    end else begin
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, ~(out_valid & ~out_ready)});
      if (out_valid && out_ready) begin
        if (q7.size() == 0) begin
          checkOutput("sb_empty_s7", 32'd1, 32'd0);
        end else begin
          e7 = q7.pop_front();
          checkOutput("result_s7", {15'd0, ovf, result}, {15'd0, e7});
        end
      end
      if (out_valid_s0 && out_ready) begin
        if (q0.size() == 0) begin
          checkOutput("sb_empty_s0", 32'd1, 32'd0);
        end else begin
          e0 = q0.pop_front();
          checkOutput("result_s0", {15'd0, ovf_s0, result_s0}, {15'd0, e0});
        end
      end
      if (in_valid && in_ready) begin
        q7.push_back(model(fp_sel, man, exp, sgn, 7));
        q0.push_back(model(fp_sel, man, exp, sgn, 0));
      end
    end
  end

  // Present one triple and hold it until it has been accepted
  task automatic applyStimulus(input logic f, input logic [15:0] m,
                               input logic [3:0] ex, input logic s);
    bit ok;
    in_valid = 1'b1;
    fp_sel   = f;
    man      = m;
    exp      = ex;
    sgn      = s;
    ok       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Stop driving and wait for the scoreboard to empty
  task automatic drain(input string tag);
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q7.size() == 0 && q0.size() == 0 && !out_valid) break;
    end
    checkOutput(tag, q7.size() + q0.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_fp_man();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1, 2:    return {1'b1, r[14:0]};
      default: return {2'b01, r[13:0]};
    endcase
  endfunction

  initial begin
    int lat;
    logic [15:0] r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    fp_sel    = 1'b0;
    man       = 16'h0000;
    exp       = 4'h0;
    sgn       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_result", {16'd0, result}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single FP 1.0 with latency measurement
    applyStimulus(1'b1, 16'h4000, 4'd7, 1'b0);
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    checkOutput("latency", lat, 32'd3);
    checkOutput("fp_one", {16'd0, result}, 32'h3800);
    checkOutput("fp_one_ovf", {31'd0, ovf}, 32'd0);
    drain("drain_single");

    // Directed vectors streamed back to back
    applyStimulus(1'b1, 16'h9000, 4'd7, 1'b0);
    applyStimulus(1'b1, 16'h4004, 4'd7, 1'b0);
    applyStimulus(1'b1, 16'h400C, 4'd7, 1'b0);
    applyStimulus(1'b1, 16'h7FFC, 4'd7, 1'b0);
    applyStimulus(1'b1, 16'h8000, 4'd15, 1'b1);
    applyStimulus(1'b1, 16'h0000, 4'd9, 1'b1);
    applyStimulus(1'b0, 16'(16'd10000 << 2), 4'd3, 1'b1);
    applyStimulus(1'b0, 16'(16'd200 << 2), 4'd0, 1'b0);
    applyStimulus(1'b0, 16'hFFFC, 4'd0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 4'd0, 1'b1);
    drain("drain_directed");

    // Random mixed stream
    for (int i = 0; i < 30; i++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        applyStimulus(1'b1, rand_fp_man(), 4'($urandom), r[0]);
      else
        applyStimulus(1'b0, {r[15:2], 2'b00}, 4'($urandom), r[1]);
    end
    drain("drain_random");

    // Backpressure: hold out_ready low for 4 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          applyStimulus(1'b1, {2'b01, 14'(i * 997)}, 4'(i + 2), i[0]);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset in the middle of a stream discards everything in flight
    applyStimulus(1'b1, 16'h4000, 4'd5, 1'b0);
    applyStimulus(1'b1, 16'hC000, 4'd6, 1'b1);
    applyStimulus(1'b0, 16'h1234, 4'd0, 1'b0);
    applyStimulus(1'b0, 16'h4321, 4'd0, 1'b1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_result", {16'd0, result}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_rst_idle", {31'd0, out_valid | out_valid_s0}, 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 16'h9000, 4'd7, 1'b1);
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mul_pack.md
Name: mul_pack

Overview:
- Result-side counterpart of the multiplier front-end.
- Consumes the unpacked product triple (16-bit mantissa, 4-bit biased exponent, sign) and re-encodes it into the packed operand word format.
- FP mode output: FP16 variant {sign, exp[3:0], frac[10:0]}, bias 7, hidden bit implied by any non-zero magnitude, no subnormals.
- INT mode output: int8 sign-magnitude.
- Three-stage valid/ready pipeline: normalize, round, saturate/pack.

Parameters:
- EXP_BIAS, 7, exponent bias of the packed FP format; used only for documentation and bench checks, because the datapath is bias-agnostic.
- INT_SHIFT, 7, right shift applied to the INT-mode 14-bit magnitude product before rounding (legal range 0..7).

Ports:
- clk      in   1   clock
- rst_n    in   1   asynchronous active-low reset
- in_valid in   1   input triple valid
- in_ready out  1   block can accept input this cycle
- fp_sel   in   1   1 = FP mode, 0 = INT8 mode; sampled together with the triple
- man      in   16  product mantissa. FP: leading one at bit 15 or 14, or all zero. INT: [15:2] = magnitude, [1:0] = 0
- exp      in   4   biased product exponent (FP only, ignored in INT)
- sgn      in   1   product sign
- out_valid out 1   packed result valid
- out_ready in  1   downstream accepts result
- result   out  16  packed word. INT mode: {8'h00, sign, mag[6:0]}
- ovf      out  1   result saturated; qualified by out_valid

Behaviour:
- Reset (async, rst_n low): all stage valids = 0; out_valid = 0; result = 16'h0000; ovf = 0. Reset mid-operation discards all in-flight data with no partial output.
- Pipeline advance and stall:
  - Global stall condition: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - An input transfer occurs on in_valid & in_ready.
  - During a stall every stage holds its contents.
  - Empty (bubble) stages do not collapse during a stall.
  - Latency is 3 cycles from input transfer to out_valid when there is no stall.
  - Throughput is 1 result per cycle.
  - Ordering is strictly preserved.
- Stage 1, FP normalize:
  - man == 0: zero flag set.
  - man[15] = 1: frac = man[14:4], guard = man[3], sticky = |man[2:0], e = exp + 1 (5 bits).
  - Otherwise: frac = man[13:3], guard = man[2], sticky = |man[1:0], e = exp.
- Stage 1, INT:
  - mag14 = man[15:2] >> INT_SHIFT.
  - guard = bit INT_SHIFT-1 of man[15:2].
  - sticky = OR of the bits below the guard bit.
  - With INT_SHIFT = 0: guard = 0 and sticky = 0.
- Stage 2, round: round-half-to-even.
  - inc = guard & (sticky | lsb).
  - FP: a carry out of frac (all ones + 1) gives frac = 0 and e = e + 1.
- Stage 3, saturate/pack:
  - FP, e > 15: result = {sgn, 15'h7FFF}, ovf = 1.
  - FP, zero: result = {sgn, 15'h0}.
  - FP, normal: result = {sgn, e[3:0], frac}.
  - INT, rounded magnitude > 127: mag = 127, ovf = 1.
  - INT: result = {8'h00, sgn, mag[6:0]}.
- fp_sel, sgn and the zero flag travel with the data through every stage.
- Simultaneous in transfer and out transfer in the same cycle is legal. A full pipeline streams with no bubble.

Optional Feature:
- Macro: MUL_PACK_STATUS_EN.
- When defined, the block adds these ports:
  - stat_clr in 1: synchronous clear, with priority over set.
  - stat_ovf out 1: sticky, set on any transferred result with ovf.
  - stat_inexact out 1: sticky, set when a transferred result had guard | sticky.
  - stat_cnt out 8: count of saturated results, saturating at 255.
- Updates happen only on output transfer. All of these reset to 0.
- When undefined, none of these ports or registers exist and the behaviour is otherwise identical.

Decomposition:
- Shared package:
  - FP field widths (SGN_W = 1, EXP_W = 4, FRAC_W = 11).
  - Default bias 7.
  - FP_MAX_MAG = 15'h7FFF.
  - INT_MAX_MAG = 7'h7F.
  - A stage-payload typedef {fp, sgn, zero, e[4:0], frac/mag, guard, sticky}.
- One sub-module, mul_pack_round, holding the combinational RNE increment with carry-out. It is reused for both FP and INT.

Test Plan:
- FP, man = 16'h4000, exp = 7, sgn = 0 -> result 16'h3800 (1.0) after 3 cycles, ovf = 0.
- FP, man = 16'h9000, exp = 7 (1.5 × 1.5) -> 16'h4100 (2.25).
- FP rounding:
  - man = 16'h4004, exp = 7 -> 16'h3800 (tie to even).
  - man = 16'h400C -> 16'h3802.
  - man = 16'h7FFC -> carry into exponent -> 16'h4000.
- FP overflow: man = 16'h8000, exp = 15, sgn = 1 -> 16'hFFFF, ovf = 1.
- FP zero: man = 0, sgn = 1 -> 16'h8000.
- INT, man[15:2] = 10000, sgn = 1, INT_SHIFT = 7 -> 16'h00CE.
- INT saturation with INT_SHIFT = 0, man[15:2] = 200 -> 16'h007F, ovf = 1.
- Backpressure:
  - Stream 6 inputs while holding out_ready low for 4 cycles mid-stream.
  - Required: in_ready drops while out_valid & ~out_ready; all 6 results emerge in order with no loss or duplication.
  - Assert rst_n low mid-stream: out_valid = 0 at once and no stale data appears afterwards.
